// File: rtl/writeback_unit.sv
//==============================================================================
// Module      : writeback_unit
// Description : Final stage of the RV32I core. Accepts one retiring instruction
//               at a time over a valid/ready handshake, selects the result
//               source, waits for the load response, aligns/extends load data
//               and drives the register file write port.
//               Optional macro WB_LOAD_TIMEOUT_EN adds a WAIT_MEM timeout that
//               aborts a load after TIMEOUT_CYCLES cycles without a response.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module writeback_unit #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_valid,
  output logic            wb_ready,
  input  logic [4:0]      wb_rd,
  input  logic [1:0]      wb_sel,
  input  logic [2:0]      wb_funct3,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] imm,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wd,
  output logic            load_err,
  output logic [XLEN-1:0] retire_count
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;
  localparam logic [1:0] SEL_IMM  = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  // Context of the load in flight, captured at acceptance
  logic [4:0] lat_rd;
  logic [2:0] lat_funct3;
  logic [1:0] lat_addr;

  // Decoded events for the current cycle
  logic            accept;
  logic            write_now;
  logic            load_bad;
  logic            mem_done;
  logic            timeout;
  logic [XLEN-1:0] sel_value;
  logic [XLEN-1:0] load_data;

  // Legal encoding and natural alignment of a load
  function automatic logic load_ok(input logic [2:0] f3, input logic [1:0] addr);
    logic ok;
    case (f3)
      F3_LB, F3_LBU: ok = 1'b1;
      F3_LH, F3_LHU: ok = ~addr[0];
      F3_LW:         ok = (addr == 2'b00);
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Pick the addressed byte/halfword lane out of the word and extend it
  function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                               input logic [1:0]  addr,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (addr)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = addr[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_LB:   res = {{24{b[7]}}, b};
      F3_LH:   res = {{16{h[15]}}, h};
      F3_LBU:  res = {24'd0, b};
      F3_LHU:  res = {16'd0, h};
      default: res = word;
    endcase
    return res;
  endfunction

`ifdef WB_LOAD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             cnt_expired;

  assign cnt_expired = (wait_cnt == CNT_LAST);

  // Cycles spent in WAIT_MEM without a response; zero whenever not waiting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state != WAIT_MEM) begin
      wait_cnt <= '0;
    end else if (!mem_rvalid) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  logic cnt_expired;
  logic unused_timeout_cfg;

  assign cnt_expired        = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  // Result source for non-load instructions
  always_comb begin
    sel_value = alu_result;
    case (wb_sel)
      SEL_PC4: sel_value = pc_plus4;
      SEL_IMM: sel_value = imm;
      default: sel_value = alu_result;
    endcase
  end

  assign load_data = load_extract(lat_funct3, lat_addr, mem_rdata);
  assign wb_ready  = (state == IDLE);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and cycle events
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    write_now  = 1'b0;
    load_bad   = 1'b0;
    mem_done   = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (wb_valid) begin
          accept = 1'b1;
          if (wb_sel != SEL_LOAD) begin
            write_now  = 1'b1;
            next_state = WRITE;
          end else if (load_ok(wb_funct3, alu_result[1:0])) begin
            next_state = WAIT_MEM;
          end else begin
            load_bad = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        // A response in the expiry cycle still completes the load
        if (mem_rvalid) begin
          mem_done   = 1'b1;
          next_state = WRITE;
        end else if (cnt_expired) begin
          timeout    = 1'b1;
          next_state = IDLE;
        end
      end
      WRITE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Load context capture, write port and retire counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_rd       <= 5'd0;
      lat_funct3   <= 3'd0;
      lat_addr     <= 2'd0;
      rf_we        <= 1'b0;
      rf_rd        <= 5'd0;
      rf_wd        <= '0;
      load_err     <= 1'b0;
      retire_count <= '0;
    end else begin
      rf_we    <= 1'b0;
      load_err <= load_bad | timeout;
      if (accept) begin
        lat_rd     <= wb_rd;
        lat_funct3 <= wb_funct3;
        lat_addr   <= alu_result[1:0];
      end
      // The count moves together with the write so both appear in WRITE
      if (write_now) begin
        rf_we        <= (wb_rd != 5'd0);
        rf_rd        <= wb_rd;
        rf_wd        <= sel_value;
        retire_count <= retire_count + 1'b1;
      end else if (mem_done) begin
        rf_we        <= (lat_rd != 5'd0);
        rf_rd        <= lat_rd;
        rf_wd        <= load_data;
        retire_count <= retire_count + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
